// File: rtl/eth_phy_10g_tx_fault_gen_if.sv
// Encoded TX block stream in and out of the fault generator, together with the RX link status and the config/status sideband.
interface eth_phy_10g_tx_fault_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] encoded_tx_data;
  logic [HDR_WIDTH-1:0]  encoded_tx_hdr;
  logic [DATA_WIDTH-1:0] serdes_tx_data;
  logic [HDR_WIDTH-1:0]  serdes_tx_hdr;
  logic                  rx_block_lock;
  logic                  rx_high_ber;
  logic                  cfg_tx_fault_enable;
  logic                  status_tx_fault_active;

  modport master (
    output encoded_tx_data, encoded_tx_hdr, rx_block_lock, rx_high_ber, cfg_tx_fault_enable,
    input  serdes_tx_data, serdes_tx_hdr, status_tx_fault_active
  );

  modport slave (
    input  encoded_tx_data, encoded_tx_hdr, rx_block_lock, rx_high_ber, cfg_tx_fault_enable,
    output serdes_tx_data, serdes_tx_hdr, status_tx_fault_active
  );
endinterface

// File: rtl/eth_phy_10g_tx_fault_gen.sv
// 10GBASE-R TX fault generator: replaces the encoded stream with Remote Fault blocks while the RX link is unhealthy,
// holds RF for 125 us after recovery, then resumes passthrough on a frame boundary.
module eth_phy_10g_tx_fault_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int COUNT_125US = int'(125000/6.4)
) (
  input  logic                       clk,
  input  logic                       rst,
  eth_phy_10g_tx_fault_gen_if.slave  bus
);

  localparam int unsigned COUNT_WIDTH = $clog2(COUNT_125US + 1);

  localparam logic [1:0]  HDR_CTRL   = 2'b01;
  localparam logic [63:0] IDLE_BLOCK = 64'h00000000_0000001E;
  localparam logic [63:0] RF_BLOCK   = 64'h00000000_0200004B;
  localparam logic [63:0] ERR_BLOCK  = {{8{7'h1E}}, 8'h1E};

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_fault_gen: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_fault_gen: HDR_WIDTH must be 2");
  end

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_FAULT  = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [COUNT_WIDTH-1:0]  timer, timer_nxt;
  logic                    in_frame, in_frame_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic [HDR_WIDTH-1:0]    hdr_nxt;
  logic                    active_nxt;

  logic       fault_cond;
  logic       is_ctrl;
  logic       frame_start;
  logic       safe;
  logic [7:0] blk_type;

  assign fault_cond  = bus.cfg_tx_fault_enable & (~bus.rx_block_lock | bus.rx_high_ber);
  assign blk_type    = bus.encoded_tx_data[7:0];
  assign is_ctrl     = (bus.encoded_tx_hdr == HDR_CTRL);
  assign frame_start = is_ctrl & ((blk_type == 8'h78) | (blk_type == 8'h33) | (blk_type == 8'h66));
  // Boundary check uses the tracker value from before this block updates it.
  assign safe        = is_ctrl & ~in_frame;

  // Frame tracker follows the input stream in every state; only control blocks move it.
  always_comb begin
    in_frame_nxt = in_frame;
    if (is_ctrl) begin
      in_frame_nxt = frame_start;
    end
  end

  // Next state and output block selection.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    hdr_nxt    = HDR_CTRL;
    data_nxt   = RF_BLOCK;
    active_nxt = 1'b1;
    case (state)
      ST_PASS: begin
        if (fault_cond) begin
          state_nxt = ST_FAULT;
          // Truncate a frame in flight with an error block so the far end discards it.
          if (in_frame) begin
            data_nxt = ERR_BLOCK;
          end
        end else begin
          hdr_nxt    = bus.encoded_tx_hdr;
          data_nxt   = bus.encoded_tx_data;
          active_nxt = 1'b0;
        end
      end
      ST_FAULT: begin
        if (!bus.cfg_tx_fault_enable) begin
          state_nxt = ST_RESUME;
        end else if (!fault_cond) begin
          state_nxt = ST_CLEAR;
          timer_nxt = COUNT_WIDTH'(COUNT_125US);
        end
      end
      ST_CLEAR: begin
        if (!bus.cfg_tx_fault_enable) begin
          state_nxt = ST_RESUME;
        end else if (fault_cond) begin
          state_nxt = ST_FAULT;
        end else if (timer != '0) begin
          timer_nxt = timer - COUNT_WIDTH'(1);
        end else begin
          state_nxt = ST_RESUME;
        end
      end
      ST_RESUME: begin
        if (fault_cond) begin
          state_nxt = ST_FAULT;
        end else if (safe) begin
          state_nxt  = ST_PASS;
          hdr_nxt    = bus.encoded_tx_hdr;
          data_nxt   = bus.encoded_tx_data;
          active_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= ST_PASS;
      timer                      <= COUNT_WIDTH'(COUNT_125US);
      in_frame                   <= 1'b0;
      bus.serdes_tx_hdr          <= HDR_CTRL;
      bus.serdes_tx_data         <= IDLE_BLOCK;
      bus.status_tx_fault_active <= 1'b0;
    end else begin
      state                      <= state_nxt;
      timer                      <= timer_nxt;
      in_frame                   <= in_frame_nxt;
      bus.serdes_tx_hdr          <= hdr_nxt;
      bus.serdes_tx_data         <= data_nxt;
      bus.status_tx_fault_active <= active_nxt;
    end
  end

endmodule
